// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared widths, token field positions and scheduler states
package lz77_pkg;

  localparam int DATA_W      = 8;
  localparam int CURSOR_W    = 7;
  localparam int STREAM_W    = 16;
  localparam int LEN_W       = 4;
  localparam int TIMEOUT_CYC = 1023;

  localparam int TOK_MATCH_BIT = STREAM_W - 1;
  localparam int TOK_LEN_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_FINISH
  } sched_state_e;

endpackage

// File: rtl/lz_match_sched_if.sv
// rtl/lz_match_sched_if.sv - match-engine handshake and token stream bundle
interface lz_match_sched_if
  import lz77_pkg::*;
#(
  parameter int data_width     = DATA_W,
  parameter int cursor_width   = CURSOR_W,
  parameter int lzStream_width = STREAM_W
);

  logic                      m_start;
  logic [cursor_width-1:0]   m_cursor;
  logic [data_width-1:0]     m_data;
  logic                      m_done;
  logic [lzStream_width-1:0] m_stream;
  logic                      tok_valid;
  logic [lzStream_width-1:0] tok_data;
  logic                      tok_last;
  logic                      tok_ready;

  modport master (
    output m_start, m_cursor, m_data, tok_valid, tok_data, tok_last,
    input  m_done, m_stream, tok_ready
  );

  modport slave (
    input  m_start, m_cursor, m_data, tok_valid, tok_data, tok_last,
    output m_done, m_stream, tok_ready
  );

endinterface

// File: rtl/lz_window_buf.sv
// rtl/lz_window_buf.sv - window buffer, one write port and one registered read port
module lz_window_buf
  import lz77_pkg::*;
#(
  parameter int data_width   = DATA_W,
  parameter int cursor_width = CURSOR_W
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [cursor_width-1:0] wr_addr_i,
  input  logic [data_width-1:0]   wr_data_i,
  input  logic [cursor_width-1:0] rd_addr_i,
  output logic [data_width-1:0]   rd_data_o
);

  logic [data_width-1:0] mem_q [2**cursor_width];
  logic [data_width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lz_match_sched.sv
// rtl/lz_match_sched.sv - walks a cursor through one block, issuing engine jobs and forwarding tokens
module lz_match_sched
  import lz77_pkg::*;
#(
  parameter int data_width     = DATA_W,
  parameter int cursor_width   = CURSOR_W,
  parameter int lzStream_width = STREAM_W,
  parameter int LEN_WIDTH      = LEN_W,
  parameter int TIMEOUT        = TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [cursor_width-1:0] wr_addr,
  input  logic [data_width-1:0]   wr_data,
  input  logic                    blk_start,
  input  logic [cursor_width:0]   blk_len,
  output logic                    blk_busy,
  output logic                    blk_done,
  output logic                    err_timeout,
  lz_match_sched_if.master        eng
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int PW    = cursor_width + 2;
  localparam logic [cursor_width:0] WIN_BYTES = {1'b1, {cursor_width{1'b0}}};

  sched_state_e              state_q, state_d;
  logic [cursor_width:0]     len_q, len_d;
  logic [cursor_width:0]     cursor_q, cursor_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [lzStream_width-1:0] tok_q, tok_d;
  logic [data_width-1:0]     mdata_q, mdata_d;
  logic                      err_q, err_d;

  logic [data_width-1:0]     rd_data;
  logic [LEN_WIDTH-1:0]      len_field;
  logic [PW-1:0]             advance;
  logic [PW-1:0]             next_pos;
  logic                      last_c;
  logic                      timeout_hit;

  lz_window_buf #(
    .data_width   (data_width),
    .cursor_width (cursor_width)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en && !blk_busy),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (cursor_q[cursor_width-1:0]),
    .rd_data_o (rd_data)
  );

  // A zero-length match still has to consume one byte or the cursor would stall.
  assign len_field = tok_q[LEN_WIDTH-1:0];
  always_comb begin
    advance = PW'(1);
    if (tok_q[lzStream_width-1] && (len_field != '0)) begin
      advance = PW'(len_field);
    end
  end

  assign next_pos    = {1'b0, cursor_q} + advance;
  assign last_c      = next_pos >= {1'b0, len_q};
  // A done arriving on the very cycle the limit is reached wins over the timeout.
  assign timeout_hit = (state_q == S_WAIT) && !eng.m_done && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    tok_d    = tok_q;
    mdata_d  = mdata_q;
    err_d    = err_q | timeout_hit;
    case (state_q)
      S_IDLE: begin
        if (blk_start) begin
          len_d    = (blk_len > WIN_BYTES) ? WIN_BYTES : blk_len;
          cursor_d = '0;
          state_d  = (blk_len == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        mdata_d = rd_data;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng.m_done) begin
          tok_d   = eng.m_stream;
          state_d = S_EMIT;
        end else if (timeout_hit) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (eng.tok_ready) begin
          cursor_d = next_pos[cursor_width:0];
          state_d  = last_c ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      tok_q    <= '0;
      mdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      tok_q    <= tok_d;
      mdata_q  <= mdata_d;
      err_q    <= err_d;
    end
  end

  assign blk_busy      = (state_q != S_IDLE);
  assign blk_done      = (state_q == S_FINISH);
  assign err_timeout   = err_q | timeout_hit;
  assign eng.m_start   = (state_q == S_ISSUE);
  assign eng.m_cursor  = cursor_q[cursor_width-1:0];
  assign eng.m_data    = (state_q == S_ISSUE) ? rd_data : mdata_q;
  assign eng.tok_valid = (state_q == S_EMIT);
  assign eng.tok_data  = tok_q;
  assign eng.tok_last  = (state_q == S_EMIT) && last_c;

endmodule
